// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Sequencing FSM for the multicycle RV32I core. One memory port is shared by
// instruction fetch and data access, and one ALU computes PC+4, the branch
// target and the execute result. Outputs are a Mealy function of the current
// state and the inputs.
//
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   op, funct3,   instruction fields from the datapath IR
//   funct7_5
//   EQ            ALU zero flag (operands equal)
//   mem_ready     memory completes the access this cycle
//   mem_req       memory access request
//   AdrSrc        memory address select: 0 = PC, 1 = ALUOut
//   IRWrite       load IR and OldPC
//   PCWrite       load PC from the result mux
//   RegWrite      register file write enable
//   MemWrite      store strobe, qualified by mem_req
//   ALUSrcA/B     ALU operand selects
//   ALUctrl       ALU operation
//   ImmSrc        immediate format select
//   ResultSrc     result mux select
//   state_o       current state (debug)
//   illegal       high while trapped on an unsupported instruction
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    input  logic               EQ,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               AdrSrc,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUctrl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ResultSrc,
    output logic [STATE_W-1:0] state_o,
    output logic               illegal
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECR    = STATE_W'(6),
        EXECI    = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9),
        TRAP     = STATE_W'(15)
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    state_t state, state_next;

    function automatic logic alu_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // sub_sel is only honoured for funct3=000; I-type callers pass 0.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
        logic [2:0] ctrl;
        ctrl = 3'b000;
        case (f3)
            3'b000:  ctrl = sub_sel ? 3'b001 : 3'b000;
            3'b010:  ctrl = 3'b101;
            3'b110:  ctrl = 3'b011;
            3'b111:  ctrl = 3'b010;
            default: ctrl = 3'b000;
        endcase
        return ctrl;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUctrl    = 3'b000;
        ImmSrc     = 2'b00;
        ResultSrc  = 2'b00;
        illegal    = 1'b0;

        unique case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                if ((op == OP_LW || op == OP_SW) && funct3 == 3'b010)
                    state_next = MEMADR;
                else if (op == OP_R && alu_legal(funct3))
                    state_next = EXECR;
                else if (op == OP_I && alu_legal(funct3))
                    state_next = EXECI;
                else if (op == OP_BR && funct3[2:1] == 2'b00)
                    state_next = BRANCH;
                else
                    state_next = TRAP;
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = (op == OP_SW) ? 2'b01 : 2'b00;
                state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUctrl    = alu_decode(funct3, funct7_5);
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUctrl    = alu_decode(funct3, 1'b0);
                state_next = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUctrl    = 3'b001;
                PCWrite    = (funct3 == 3'b000 && EQ) || (funct3 == 3'b001 && !EQ);
                state_next = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                // Unused encodings are treated as a fault.
                state_next = TRAP;
            end
        endcase

        // Reset abandons any access in flight: no strobes, FETCH selects.
        if (rst) begin
            mem_req   = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b10;
            ALUctrl   = 3'b000;
            ImmSrc    = 2'b00;
            ResultSrc = 2'b10;
            illegal   = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       EQ;
    logic       mem_ready;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
    logic [2:0] ALUctrl;
    logic [3:0] state_o;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .EQ(EQ), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
        .state_o(state_o), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic [1:0] rs;
        logic       ill;
    } outs_t;

    outs_t exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic outs_t mk(logic [3:0] st, logic req, logic adr, logic irw,
                                 logic pcw, logic rw, logic mw, logic [1:0] sa,
                                 logic [1:0] sb, logic [2:0] alu, logic [1:0] imm,
                                 logic [1:0] rs, logic ill);
        outs_t o;
        o = '{st, req, adr, irw, pcw, rw, mw, sa, sb, alu, imm, rs, ill};
        return o;
    endfunction

    // Expected-output constructors for each state, written from the state table.
    function automatic outs_t x_fetch(logic rdy);
        return mk(4'd0, 1, 0, rdy, rdy, 0, 0, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 0);
    endfunction
    function automatic outs_t x_rst(logic [3:0] st);
        return mk(st, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 0);
    endfunction
    function automatic outs_t x_decode();
        return mk(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b10, 2'b00, 0);
    endfunction
    function automatic outs_t x_memadr(logic [1:0] imm);
        return mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, imm, 2'b00, 0);
    endfunction
    function automatic outs_t x_memread();
        return mk(4'd3, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
    endfunction
    function automatic outs_t x_memwb();
        return mk(4'd4, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01, 0);
    endfunction
    function automatic outs_t x_memwrite();
        return mk(4'd5, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
    endfunction
    function automatic outs_t x_execr(logic [2:0] alu);
        return mk(4'd6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, alu, 2'b00, 2'b00, 0);
    endfunction
    function automatic outs_t x_execi(logic [2:0] alu);
        return mk(4'd7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, alu, 2'b00, 2'b00, 0);
    endfunction
    function automatic outs_t x_aluwb();
        return mk(4'd8, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
    endfunction
    function automatic outs_t x_branch(logic pcw);
        return mk(4'd9, 0, 0, 0, pcw, 0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 0);
    endfunction
    function automatic outs_t x_trap();
        return mk(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1);
    endfunction

    // Push expectation for the current cycle, sample at the falling edge,
    // compare, then advance to just after the next rising edge.
    task automatic chk(input string tag, input outs_t e);
        outs_t obs, ex;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = '{state_o, mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, ResultSrc, illegal};
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        n_cmp++;
        assert (obs === ex) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", t, obs, ex);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7_5 = f7;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; op = '0; funct3 = '0; funct7_5 = 1'b0; EQ = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", x_rst(4'd0));
        rst = 1'b0;

        // Reset release, then lw x5,8(x1) with two wait cycles in FETCH and MEMREAD.
        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0; chk("lw_fetch_w0", x_fetch(0));
        mem_ready = 1'b0; chk("lw_fetch_w1", x_fetch(0));
        mem_ready = 1'b1; chk("lw_fetch_rdy", x_fetch(1));
        mem_ready = 1'b0; chk("lw_decode", x_decode());
        chk("lw_memadr", x_memadr(2'b00));
        chk("lw_memread_w0", x_memread());
        chk("lw_memread_w1", x_memread());
        mem_ready = 1'b1; chk("lw_memread_rdy", x_memread());
        chk("lw_memwb", x_memwb());

        // R-type sub, zero wait.
        set_instr(7'b0110011, 3'b000, 1'b1);
        chk("sub_fetch", x_fetch(1));
        chk("sub_decode", x_decode());
        chk("sub_execr", x_execr(3'b001));
        chk("sub_aluwb", x_aluwb());

        // R-type or.
        set_instr(7'b0110011, 3'b110, 1'b0);
        chk("or_fetch", x_fetch(1));
        chk("or_decode", x_decode());
        chk("or_execr", x_execr(3'b011));
        chk("or_aluwb", x_aluwb());

        // I-type slti: funct7_5 set but ignored.
        set_instr(7'b0010011, 3'b010, 1'b1);
        chk("slti_fetch", x_fetch(1));
        chk("slti_decode", x_decode());
        chk("slti_execi", x_execi(3'b101));
        chk("slti_aluwb", x_aluwb());

        // Branches: beq taken / not taken, bne taken / not taken.
        set_instr(7'b1100011, 3'b000, 1'b0); EQ = 1'b1;
        chk("beq_t_fetch", x_fetch(1)); chk("beq_t_decode", x_decode());
        chk("beq_t_branch", x_branch(1));
        EQ = 1'b0;
        chk("beq_n_fetch", x_fetch(1)); chk("beq_n_decode", x_decode());
        chk("beq_n_branch", x_branch(0));
        set_instr(7'b1100011, 3'b001, 1'b0); EQ = 1'b0;
        chk("bne_t_fetch", x_fetch(1)); chk("bne_t_decode", x_decode());
        chk("bne_t_branch", x_branch(1));
        EQ = 1'b1;
        chk("bne_n_fetch", x_fetch(1)); chk("bne_n_decode", x_decode());
        chk("bne_n_branch", x_branch(0));
        EQ = 1'b0;

        // sw with three wait cycles: strobes held four cycles.
        set_instr(7'b0100011, 3'b010, 1'b0);
        chk("sw_fetch", x_fetch(1));
        chk("sw_decode", x_decode());
        chk("sw_memadr", x_memadr(2'b01));
        mem_ready = 1'b0;
        chk("sw_memwrite_w0", x_memwrite());
        chk("sw_memwrite_w1", x_memwrite());
        chk("sw_memwrite_w2", x_memwrite());
        mem_ready = 1'b1; chk("sw_memwrite_rdy", x_memwrite());

        // sw aborted by reset on the second wait cycle.
        chk("swr_fetch", x_fetch(1));
        chk("swr_decode", x_decode());
        chk("swr_memadr", x_memadr(2'b01));
        mem_ready = 1'b0;
        chk("swr_memwrite_w0", x_memwrite());
        rst = 1'b1; chk("swr_rst_cycle", x_rst(4'd5));
        rst = 1'b0; chk("swr_after_rst", x_fetch(0));

        // Illegal opcode traps until reset.
        set_instr(7'b1111111, 3'b000, 1'b0);
        mem_ready = 1'b1;
        chk("ill_fetch", x_fetch(1));
        chk("ill_decode", x_decode());
        for (int i = 0; i < 10; i++) chk($sformatf("ill_trap_%0d", i), x_trap());
        rst = 1'b1; chk("ill_rst_cycle", x_rst(4'd15));
        rst = 1'b0; mem_ready = 1'b0;
        chk("ill_after_rst", x_fetch(0));

        // lw with a bad funct3 also traps.
        set_instr(7'b0000011, 3'b000, 1'b0);
        mem_ready = 1'b1;
        chk("lwbad_fetch", x_fetch(1));
        chk("lwbad_decode", x_decode());
        chk("lwbad_trap", x_trap());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Sequencing FSM for the multicycle variant of the RV32I core. The datapath shares one memory port for instruction and data and reuses one ALU for PC+4, branch target and execute. This block replaces the single-cycle control decode with a registered state machine. It reads the instruction fields held in the datapath IR, plus the EQ flag, and drives every enable and mux select each cycle. Memory accesses use a req/ready handshake so the memory can stall.

Parameters:
STATE_W, 4, width of the state register and of state_o.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
EQ  in  1  ALU zero flag, ALU operands equal
mem_ready  in  1  memory completes the access this cycle
mem_req  out  1  memory access request
AdrSrc  out  1  0 = PC, 1 = ALUOut
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  load PC from the result mux
RegWrite  out  1  register file write enable
MemWrite  out  1  store strobe, valid with mem_req
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  2  00 = I, 01 = S, 10 = B
ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
state_o  out  4  current state, for debug
illegal  out  1  high while in TRAP

Behaviour:
- Reset: clk and rst are fixed as above; reset is synchronous and active-high. On a clk edge with rst=1, state becomes FETCH.
  - While rst=1, mem_req, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0 combinationally.
  - Selects take their FETCH values. illegal=0.
  - Reset asserted mid-operation, including mid-handshake, abandons the access with no write strobe.
- Outputs are a combinational function of state and inputs (Mealy). Any select not listed for a state is 00 / 000.
- State encoding (state_o): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, TRAP 15.
- FETCH: mem_req=1, AdrSrc=0, SrcA=00, SrcB=10, add, ResultSrc=10.
  - Stays in FETCH while mem_ready=0.
  - In the mem_ready=1 cycle, IRWrite=1 and PCWrite=1 (PC<=PC+4), then go to DECODE.
- DECODE: SrcA=01, SrcB=01, ImmSrc=10, add (branch target into ALUOut). Next state:
  - lw 0000011 and funct3=010 -> MEMADR
  - sw 0100011 and funct3=010 -> MEMADR
  - R-type 0110011 and legal ALU op -> EXECR
  - I-ALU 0010011 and legal ALU op -> EXECI
  - 1100011 and funct3 in {000, 001} -> BRANCH
  - anything else -> TRAP
  - Legal ALU op, by funct3: 000 add (sub if R-type and funct7_5=1), 010 slt, 110 or, 111 and.
- MEMADR: SrcA=10, SrcB=01, add. ImmSrc=00 for lw, 01 for sw. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, held stable until the mem_ready cycle inclusive, then FETCH.
- EXECR: SrcA=10, SrcB=00, ALUctrl decoded, then ALUWB.
- EXECI: SrcA=10, SrcB=01, ImmSrc=00, ALUctrl decoded (funct7_5 ignored), then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00. PCWrite=(funct3==000 & EQ) | (funct3==001 & ~EQ). Then FETCH.
- TRAP: all strobes 0, illegal=1. Left only by reset.
- Latency with zero-wait memory (mem_ready=1 on the first req cycle): R/I 4 cycles, lw 5, sw 4, branch 3. Each wait cycle adds 1.
- The IR-derived inputs (op, funct3, funct7_5) are only sampled from DECODE onward. They are don't-care in FETCH.
- At most one of RegWrite/MemWrite is high in any cycle. IRWrite is high only in FETCH.

Test Plan:
- Reset: hold rst 2 cycles, release -> state_o=0, mem_req=1, all write strobes 0. No IRWrite until mem_ready=1.
- lw x5,8(x1) with mem_ready low for 2 cycles in FETCH and in MEMREAD -> state sequence 0,0,0,1,2,3,3,3,4,0. RegWrite=1 with ResultSrc=01 only in state 4.
- R-type, funct3=000, funct7_5=1 (sub), zero wait -> 0,1,6,8,0; ALUctrl=001 in state 6. Repeat with funct3=110 -> ALUctrl=011.
- beq (funct3=000): EQ=1 -> PCWrite=1 in BRANCH; EQ=0 -> PCWrite=0. bne (funct3=001): inverse. Both return to FETCH after 3 cycles.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite and mem_req held high 4 cycles, AdrSrc=1; assert rst on the 2nd wait cycle -> strobes drop that cycle, state_o=0 next cycle.
- op=1111111 (illegal) -> DECODE goes to TRAP. illegal=1 and state_o=15 held for 10 cycles; rst returns it to FETCH.
